// File: rtl/tetris_pkg.sv
// tetris_pkg: types and constants shared between the piece spawner and the
// game executioner.
//   piece_type_t    : 3-bit piece identifier, 0..6 are real pieces
//   active_piece_t  : spawn/active piece record {x, y, rotation, piece_type}
//   spawnState_t    : spawner fill/run state
//   legalSeed()     : maps the illegal all-zero LFSR seed to the default seed
package tetris_pkg;

  typedef logic [2:0] piece_type_t;

  localparam int          PIECE_COUNT             = 7;
  localparam piece_type_t NO_PIECE                = 3'd7;
  localparam logic [15:0] PIECE_LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] PIECE_LFSR_SEED_DEFAULT = 16'hACE1;
  localparam int          SPAWN_X_DEFAULT         = 3;
  localparam int          BOARD_X_W               = 4;
  localparam int          BOARD_Y_W               = 5;

  typedef struct packed {
    logic [BOARD_X_W-1:0] x;
    logic [BOARD_Y_W-1:0] y;
    logic [1:0]           rotation;
    piece_type_t          piece_type;
  } active_piece_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } spawnState_t;

  // An all-zero state would lock a Galois LFSR, so zero falls back to the default.
  function automatic logic [15:0] legalSeed(input logic [15:0] seed);
    return (seed == 16'h0000) ? PIECE_LFSR_SEED_DEFAULT : seed;
  endfunction

endpackage

// File: rtl/piece_spawner_lfsr.sv
// piece_lfsr: 16-bit right-shifting Galois LFSR (taps PIECE_LFSR_TAPS) that
// supplies raw piece candidates to the spawner.
// Ports:
//   game_clk     in   game clock
//   reset        in   synchronous active-high reset, state <= RESET_SEED
//   enable_i     in   advance one step this cycle
//   load_i       in   load loadValue_i this cycle (wins over enable_i)
//   loadValue_i  in   16-bit value to load (caller guarantees non-zero)
//   candidate_o  out  low three bits of the current state
module piece_lfsr
  import tetris_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = PIECE_LFSR_SEED_DEFAULT
) (
  input  logic        game_clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic [15:0] loadValue_i,
  output piece_type_t candidate_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Galois step: shift right, fold the tap mask in when a one falls out.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = loadValue_i;
    end else if (enable_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? PIECE_LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      lfsr_q <= RESET_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign candidate_o = lfsr_q[2:0];

endmodule

// File: rtl/piece_spawner.sv
// piece_spawner: deals spawn records to the game executioner, one per take.
// Piece types come from a 16-bit LFSR, pass a candidate filter and fill a
// QUEUE_DEPTH-entry preview FIFO whose head drives new_piece.
// Optional feature macro: PIECE_SPAWNER_7BAG_EN enables the 7-bag filter
// (every 7 consecutive pieces form a permutation of 0..6); without it only
// candidate 7 is rejected and pieces follow the LFSR stream directly.
// Ports:
//   game_clk         in   game clock
//   reset            in   synchronous active-high reset
//   take             in   consume the head piece this cycle
//   reseed           in   load seed_value, flush queue and bag (beats take)
//   seed_value       in   new LFSR seed, 0 selects 16'hACE1
//   new_piece        out  {x=SPAWN_X, y=0, rotation=0, piece_type=head}
//   new_piece_valid  out  queue holds at least one piece
//   next_piece_type  out  preview entry 1, 0 when fewer than 2 pieces
//   underflow        out  sticky, take seen with an empty queue
//   pieces_dealt     out  count of accepted takes, wraps
module piece_spawner
  import tetris_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 3,
  parameter int          SPAWN_X     = SPAWN_X_DEFAULT,
  parameter logic [15:0] SEED        = PIECE_LFSR_SEED_DEFAULT
) (
  input  logic          game_clk,
  input  logic          reset,
  input  logic          take,
  input  logic          reseed,
  input  logic [15:0]   seed_value,
  output active_piece_t new_piece,
  output logic          new_piece_valid,
  output piece_type_t   next_piece_type,
  output logic          underflow,
  output logic [15:0]   pieces_dealt
);

  localparam int                CW      = 4;
  localparam logic [CW-1:0]     DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [15:0]       RESET_SEED = legalSeed(SEED);

  spawnState_t   state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  piece_type_t   queue_q [QUEUE_DEPTH];
  piece_type_t   queue_d [QUEUE_DEPTH];
  logic          valid_q;
  logic          underflow_q;
  logic [15:0]   dealt_q;

  piece_type_t   candidate;
  logic          candOk;
  logic          doPop;
  logic          doPush;
  logic [CW-1:0] pushSlot;

`ifdef PIECE_SPAWNER_7BAG_EN
  logic [PIECE_COUNT-1:0] bagMask_q;
  logic [PIECE_COUNT-1:0] bagMask_d;
  logic [PIECE_COUNT-1:0] bagSet;
`endif

  // The LFSR keeps running in every state; reseed loads it instead of stepping.
  piece_lfsr #(
    .RESET_SEED (RESET_SEED)
  ) u_lfsr (
    .game_clk    (game_clk),
    .reset       (reset),
    .enable_i    (1'b1),
    .load_i      (reseed),
    .loadValue_i (legalSeed(seed_value)),
    .candidate_o (candidate)
  );

  // Candidate filter, FIFO next state and bag bookkeeping.
  // Slots at or above count are kept at zero so the head and preview outputs
  // can come straight from the queue registers. FILL is exactly the state in
  // which the queue has room, so it gates the push.
  always_comb begin
    candOk = (candidate != NO_PIECE);
`ifdef PIECE_SPAWNER_7BAG_EN
    if (candOk && bagMask_q[candidate]) begin
      candOk = 1'b0;
    end
`endif
    doPop    = take && (count_q != '0);
    doPush   = candOk && (state_q == FILL);
    pushSlot = doPop ? (count_q - 4'd1) : count_q;

    count_d = count_q;
    if (doPop && !doPush) begin
      count_d = count_q - 4'd1;
    end else if (doPush && !doPop) begin
      count_d = count_q + 4'd1;
    end

    queue_d = queue_q;
    if (doPop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        queue_d[i] = queue_q[i+1];
      end
      queue_d[QUEUE_DEPTH-1] = '0;
    end
    if (doPush) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (pushSlot == CW'(i)) begin
          queue_d[i] = candidate;
        end
      end
    end

`ifdef PIECE_SPAWNER_7BAG_EN
    // Completing the bag clears it on the same edge so the next piece starts a fresh bag.
    bagSet    = bagMask_q;
    bagMask_d = bagMask_q;
    if (doPush) begin
      bagSet    = bagMask_q | (PIECE_COUNT'(1) << candidate);
      bagMask_d = (bagSet == '1) ? '0 : bagSet;
    end
`endif
  end

  // Fill/run FSM with the queue, counters and registered status outputs.
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
      dealt_q     <= '0;
`ifdef PIECE_SPAWNER_7BAG_EN
      bagMask_q   <= '0;
`endif
    end else if (reseed) begin
      state_q   <= FILL;
      count_q   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= '0;
      valid_q   <= 1'b0;
`ifdef PIECE_SPAWNER_7BAG_EN
      bagMask_q <= '0;
`endif
    end else begin
      count_q <= count_d;
      queue_q <= queue_d;
      valid_q <= (count_d != '0);
`ifdef PIECE_SPAWNER_7BAG_EN
      bagMask_q <= bagMask_d;
`endif
      if (doPop) begin
        dealt_q <= dealt_q + 16'd1;
      end
      if (take && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end
      case (state_q)
        FILL:    if (count_d == DEPTH_C) state_q <= RUN;
        RUN:     if (count_d != DEPTH_C) state_q <= FILL;
        default: state_q <= FILL;
      endcase
    end
  end

  always_comb begin
    new_piece            = '0;
    new_piece.x          = BOARD_X_W'(SPAWN_X);
    new_piece.piece_type = queue_q[0];
  end

  assign new_piece_valid = valid_q;
  assign next_piece_type = queue_q[1];
  assign underflow       = underflow_q;
  assign pieces_dealt    = dealt_q;

endmodule

// File: tb/tb_piece_spawner.sv
// tb_piece_spawner: self-checking bench for piece_spawner (QUEUE_DEPTH=3,
// SPAWN_X=3, SEED=16'hACE1). A cycle model of the spawner keeps the expected
// preview queue as a scoreboard: accepted candidates are pushed at the edge
// they are generated and popped when a take is accepted; the DUT head and
// preview outputs are compared against it every cycle. A vector table covers
// reseed/underflow behaviour and hand sequences cover fill, bag permutation
// (with PIECE_SPAWNER_7BAG_EN) and the pieces_dealt wrap.
`timescale 1ns/1ps
module tb_piece_spawner;
  import tetris_pkg::*;

  localparam int DEPTH = 3;

  logic          game_clk = 1'b0;
  logic          reset;
  logic          take;
  logic          reseed;
  logic [15:0]   seed_value;
  active_piece_t new_piece;
  logic          new_piece_valid;
  piece_type_t   next_piece_type;
  logic          underflow;
  logic [15:0]   pieces_dealt;

  piece_spawner #(
    .QUEUE_DEPTH (DEPTH),
    .SPAWN_X     (3),
    .SEED        (16'hACE1)
  ) dut (
    .game_clk        (game_clk),
    .reset           (reset),
    .take            (take),
    .reseed          (reseed),
    .seed_value      (seed_value),
    .new_piece       (new_piece),
    .new_piece_valid (new_piece_valid),
    .next_piece_type (next_piece_type),
    .underflow       (underflow),
    .pieces_dealt    (pieces_dealt)
  );

  always #5 game_clk = ~game_clk;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn    = 1'b0;

  // Reference model state; mQueue is the scoreboard of expected queue contents.
  logic [15:0] mLfsr;
  piece_type_t mQueue [$];
  logic [15:0] mDealt;
  logic        mUnder;
`ifdef PIECE_SPAWNER_7BAG_EN
  logic [6:0]  mBag;
`endif

  piece_type_t dealtLog [$];

  typedef struct {
    logic        take;
    logic        reseed;
    logic [15:0] seed;
    logic        expValid;
    logic        expUnder;
    logic [15:0] expDealt;
    piece_type_t expType;
  } vec_t;

  vec_t vecs [8];

  task automatic finishSim();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      if (errorCount >= 50) finishSim();
    end
  endtask

  task automatic applyStimulus(input logic t, input logic rs, input logic [15:0] sv);
    @(negedge game_clk);
    take       = t;
    reseed     = rs;
    seed_value = sv;
  endtask

  function automatic logic [15:0] modelStep(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Cycle model, evaluated at the same edge the DUT samples its inputs.
  always @(posedge game_clk) begin : model
    piece_type_t cand;
    logic        ok;
    if (reset) begin
      mLfsr = 16'hACE1;
      mQueue.delete();
      mDealt = 16'h0;
      mUnder = 1'b0;
`ifdef PIECE_SPAWNER_7BAG_EN
      mBag = 7'h0;
`endif
    end else if (reseed) begin
      mLfsr = (seed_value == 16'h0) ? 16'hACE1 : seed_value;
      mQueue.delete();
`ifdef PIECE_SPAWNER_7BAG_EN
      mBag = 7'h0;
`endif
    end else begin
      cand = mLfsr[2:0];
      ok   = (cand != 3'd7) && (mQueue.size() < DEPTH);
`ifdef PIECE_SPAWNER_7BAG_EN
      if (ok && mBag[cand]) ok = 1'b0;
`endif
      if (take) begin
        if (mQueue.size() == 0) begin
          mUnder = 1'b1;
        end else begin
          void'(mQueue.pop_front());
          mDealt = mDealt + 16'd1;
        end
      end
      if (ok) begin
        mQueue.push_back(cand);
`ifdef PIECE_SPAWNER_7BAG_EN
        mBag = mBag | (7'd1 << cand);
        if (mBag == 7'h7F) mBag = 7'h0;
`endif
      end
      mLfsr = modelStep(mLfsr);
    end
  end

  // Every cycle the registered outputs must match the scoreboard.
  always @(negedge game_clk) begin
    if (checkEn) begin
      checkOutput("valid", new_piece_valid, (mQueue.size() != 0));
      checkOutput("headType", new_piece.piece_type, (mQueue.size() > 0) ? mQueue[0] : 3'd0);
      checkOutput("nextType", next_piece_type, (mQueue.size() > 1) ? mQueue[1] : 3'd0);
      checkOutput("underflow", underflow, mUnder);
      checkOutput("dealt", pieces_dealt, mDealt);
    end
  end

  task automatic doReset();
    @(negedge game_clk);
    reset  = 1'b1;
    take   = 1'b0;
    reseed = 1'b0;
    repeat (2) @(posedge game_clk);
    @(negedge game_clk);
    reset = 1'b0;
  endtask

  // Takes only when the model says a piece is available, at most one per gap cycles.
  task automatic runTakes(input int n, input int gap, input int maxCycles);
    int taken  = 0;
    int cycles = 0;
    int idle   = gap;
    while (taken < n && cycles < maxCycles) begin
      @(negedge game_clk);
      cycles++;
      if (idle >= gap && mQueue.size() > 0) begin
        take = 1'b1;
        dealtLog.push_back(new_piece.piece_type);
        taken++;
        idle = 1;
      end else begin
        take = 1'b0;
        idle++;
      end
    end
    @(negedge game_clk);
    take = 1'b0;
    checkOutput("takesDone", taken, n);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finishSim();
  end

  initial begin
    bit rose;
    bit found;

    // take, reseed, seed, expValid, expUnder, expDealt, expType
    vecs[0] = '{1'b1, 1'b1, 16'hACE1, 1'b0, 1'b0, 16'd0, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 16'hACE1, 1'b0, 1'b0, 16'd0, 3'd0};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd0, 3'd1};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd1, 3'd0};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd1, 3'd0};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'd1, 3'd0};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd1, 3'd1};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd2, 3'd0};

    reset      = 1'b1;
    take       = 1'b0;
    reseed     = 1'b0;
    seed_value = 16'h0;
    repeat (2) @(posedge game_clk);
    #1;
    checkOutput("rstValid", new_piece_valid, 0);
    checkOutput("rstType", new_piece.piece_type, 0);
    checkOutput("rstNext", next_piece_type, 0);
    checkOutput("rstUnderflow", underflow, 0);
    checkOutput("rstDealt", pieces_dealt, 0);
    checkEn = 1'b1;

    // Fill from reset: valid within 16 cycles, queue full in RUN, head 1 then 0.
    @(negedge game_clk);
    reset = 1'b0;
    rose  = 1'b0;
    for (int c = 0; c < 16 && !rose; c++) begin
      @(posedge game_clk);
      #1;
      if (new_piece_valid) rose = 1'b1;
    end
    checkOutput("validWithin16", rose, 1);
    repeat (12) @(posedge game_clk);
    #1;
    checkOutput("fillState", dut.state_q, RUN);
    checkOutput("fillCount", dut.count_q, 3);
    checkOutput("fillHead", new_piece.piece_type, 1);
    checkOutput("fillNext", next_piece_type, 0);

    // Take on every available cycle from a full queue.
    runTakes(40, 1, 400);

    // Reseed with zero restarts the 16'hACE1 sequence.
    applyStimulus(1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (12) @(posedge game_clk);
    #1;
    checkOutput("reseed0Valid", new_piece_valid, 1);
    checkOutput("reseed0Head", new_piece.piece_type, 1);
    checkOutput("reseed0Next", next_piece_type, 0);

`ifdef PIECE_SPAWNER_7BAG_EN
    // 70 spaced takes from a fresh bag: each aligned group of 7 is a permutation.
    applyStimulus(1'b0, 1'b1, 16'h1234);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    dealtLog.delete();
    runTakes(70, 2, 3000);
    for (int g = 0; g < 10; g++) begin
      logic [6:0] mask;
      mask = 7'h0;
      for (int j = 0; j < 7; j++) begin
        if ((g * 7 + j) < dealtLog.size()) mask = mask | (7'd1 << dealtLog[g*7+j]);
      end
      checkOutput("bagGroup", mask, 7'h7F);
    end
`endif

    // Reseed versus take and underflow while empty.
    doReset();
    repeat (12) @(posedge game_clk);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].take, vecs[i].reseed, vecs[i].seed);
      @(posedge game_clk);
      #1;
      checkOutput("vecValid", new_piece_valid, vecs[i].expValid);
      checkOutput("vecUnderflow", underflow, vecs[i].expUnder);
      checkOutput("vecDealt", pieces_dealt, vecs[i].expDealt);
      checkOutput("vecType", new_piece.piece_type, vecs[i].expType);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000);

    // Reset clears the sticky underflow; then preload pieces_dealt to 16'hFFFF.
    doReset();
    #1;
    checkOutput("underflowCleared", underflow, 0);
    dealtLog.delete();
    runTakes(65535, 1, 300000);
    checkOutput("dealtPreload", pieces_dealt, 16'hFFFF);
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge game_clk);
      if (mQueue.size() > 0) found = 1'b1;
    end
    checkOutput("wrapPieceReady", found, 1);
    take = 1'b1;
    @(negedge game_clk);
    take = 1'b0;
    checkOutput("dealtWrap", pieces_dealt, 16'h0000);
    checkOutput("spawnX", new_piece.x, 3);
    checkOutput("spawnY", new_piece.y, 0);
    checkOutput("spawnRot", new_piece.rotation, 0);

    repeat (2) @(posedge game_clk);
    finishSim();
  end

endmodule
